dz_matrix_scan: RTL and testbench

//  Parametrised successor of the count_game dot-matrix driver. It scans a ROWS x COLS
//  red/green LED matrix, one row at a time. Each row is held for DIV clocks, and the first

---
 rtl/dz_matrix_scan.sv | 137 +++++++++++++
 tb/tb_dz_matrix_scan.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dz_matrix_scan.sv
// rtl/dz_matrix_scan.sv - row-scanned red/green dot-matrix driver with digit glyph ROM
module dz_matrix_scan #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int DIV          = 4,
    parameter int BLANK        = 1,
    parameter int BLINK_FRAMES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [3:0]      num,
    input  logic [1:0]      color,
    input  logic            blink,
    output logic [ROWS-1:0] row,
    output logic [COLS-1:0] colr,
    output logic [COLS-1:0] colg,
    output logic            frame_start
);

    // Row index is one bit wider than strictly needed so "row < 8" is a real test for ROWS=8.
    localparam int SW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW = $clog2(ROWS + 1);
    localparam int BW = $clog2(2 * BLINK_FRAMES);

    localparam logic [SW-1:0] SLOT_LAST = SW'(DIV - 1);
    localparam logic [SW-1:0] BLANK_V   = SW'(BLANK);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [RW-1:0] GLYPH_H   = RW'(8);
    localparam logic [BW-1:0] BCNT_LAST = BW'(2 * BLINK_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_ON  = BW'(BLINK_FRAMES);

    logic [RW-1:0] row_idx, row_n;
    logic [SW-1:0] slot_cnt, slot_n;
    logic [3:0]    s_num, s_num_n;
    logic [1:0]    s_col, s_col_n;
    logic          s_blink, s_blink_n;
    logic [BW-1:0] blink_cnt, blink_cnt_n;

    logic            frame_end;
    logic            visible;
    logic            drive;
    logic [7:0]      glyph_line;
    logic [COLS-1:0] pattern;
    logic [ROWS-1:0] row_d;
    logic [COLS-1:0] colr_d, colg_d;
    logic            frame_start_d;

    // Digit glyph ROM; row 0 sits in the top byte, bit 7 is the leftmost column.
    function automatic logic [7:0] glyph_row(input logic [3:0] n, input logic [2:0] r);
        logic [63:0] g;
        logic [5:0]  base;
        case (n)
            4'd0:    g = 64'h003C_4242_4242_423C;
            4'd1:    g = 64'h0018_1838_1818_187E;
            4'd2:    g = 64'h003C_6606_0C30_607E;
            4'd3:    g = 64'h003C_6606_1C06_663C;
            4'd4:    g = 64'h000C_1C2C_4C7E_0C0C;
            4'd5:    g = 64'h007E_607C_0606_663C;
            4'd6:    g = 64'h003C_607C_6666_663C;
            4'd7:    g = 64'h007E_060C_1830_3030;
            4'd8:    g = 64'h003C_6666_3C66_663C;
            4'd9:    g = 64'h003C_6666_3E06_0C38;
            default: g = 64'h0;
        endcase
        base = {3'd7 - r, 3'b000};
        glyph_row = g[base +: 8];
    endfunction

    // Next scan position, frame-boundary shadow load and the drive derived from that next state.
    always_comb begin
        row_n       = ROW_LAST;
        slot_n      = SLOT_LAST;
        s_num_n     = s_num;
        s_col_n     = s_col;
        s_blink_n   = s_blink;
        blink_cnt_n = blink_cnt;
        frame_end   = (row_idx == ROW_LAST) && (slot_cnt == SLOT_LAST);

        if (en) begin
            if (slot_cnt == SLOT_LAST) begin
                slot_n = '0;
                row_n  = (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
            end else begin
                slot_n = slot_cnt + 1'b1;
                row_n  = row_idx;
            end
            if (frame_end) begin
                s_num_n     = num;
                s_col_n     = color;
                s_blink_n   = blink;
                blink_cnt_n = (blink_cnt == BCNT_LAST) ? '0 : blink_cnt + 1'b1;
            end
        end

        visible    = !s_blink_n || (blink_cnt_n < BLINK_ON);
        glyph_line = glyph_row(s_num_n, row_n[2:0]);
        pattern    = '0;
        if (visible && (row_n < GLYPH_H)) begin
            pattern[COLS-1 -: 8] = glyph_line;
        end

        drive         = en && !(slot_n < BLANK_V);
        row_d         = drive ? ~(ROWS'(1) << row_n) : '1;
        colr_d        = drive ? (pattern & {COLS{s_col_n[0]}}) : '0;
        colg_d        = drive ? (pattern & {COLS{s_col_n[1]}}) : '0;
        frame_start_d = en && frame_end;
    end

    // State, shadows and registered drive; reset parks the scan just before a frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_idx     <= ROW_LAST;
            slot_cnt    <= SLOT_LAST;
            s_num       <= '0;
            s_col       <= '0;
            s_blink     <= 1'b0;
            blink_cnt   <= '0;
            row         <= '1;
            colr        <= '0;
            colg        <= '0;
            frame_start <= 1'b0;
        end else begin
            row_idx     <= row_n;
            slot_cnt    <= slot_n;
            s_num       <= s_num_n;
            s_col       <= s_col_n;
            s_blink     <= s_blink_n;
            blink_cnt   <= blink_cnt_n;
            row         <= row_d;
            colr        <= colr_d;
            colg        <= colg_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_dz_matrix_scan.sv
// tb/tb_dz_matrix_scan.sv - self-checking bench for dz_matrix_scan
module tb_dz_matrix_scan;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int BF    = 2;
    localparam int FRAME = ROWS * DIV;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [3:0]      num;
    logic [1:0]      color;
    logic            blink;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] colr;
    logic [COLS-1:0] colg;
    logic            frame_start;

    int checks = 0;
    int errors = 0;

    dz_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BLANK(BLANK), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .num(num), .color(color), .blink(blink),
        .row(row), .colr(colr), .colg(colg), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    logic [63:0] glyphs [10] = '{
        64'h003C42424242423C, 64'h001818381818187E, 64'h003C66060C30607E,
        64'h003C66061C06663C, 64'h000C1C2C4C7E0C0C, 64'h007E607C0606663C,
        64'h003C607C6666663C, 64'h007E060C18303030, 64'h003C66663C66663C,
        64'h003C66663E060C38
    };

    // Reference model: position within the frame, sampled shadows, completed-frame count.
    int              m_pos;
    int              m_frames;
    int              m_num;
    int              m_col;
    bit              m_blink;
    logic [ROWS-1:0] e_row;
    logic [COLS-1:0] e_colr;
    logic [COLS-1:0] e_colg;
    logic            e_fs;

    function automatic logic [7:0] glyph_line(int n, int r);
        logic [63:0] g;
        if (n > 9 || r > 7) return 8'h00;
        g = glyphs[n];
        return g[63 - 8 * r -: 8];
    endfunction

    task automatic model_idle();
        e_row  = '1;
        e_colr = '0;
        e_colg = '0;
    endtask

    task automatic model_reset();
        m_pos    = FRAME - 1;
        m_frames = 0;
        m_num    = 0;
        m_col    = 0;
        m_blink  = 0;
        e_fs     = 1'b0;
        model_idle();
    endtask

    task automatic model_step();
        int r, s;
        logic [COLS-1:0] pat;
        if (!en) begin
            m_pos = FRAME - 1;
            e_fs  = 1'b0;
            model_idle();
            return;
        end
        e_fs  = (m_pos == FRAME - 1);
        m_pos = (m_pos + 1) % FRAME;
        if (e_fs) begin
            m_num    = num;
            m_col    = color;
            m_blink  = blink;
            m_frames = (m_frames + 1) % (2 * BF);
        end
        r = m_pos / DIV;
        s = m_pos % DIV;
        if (s < BLANK) begin
            model_idle();
        end else begin
            e_row = ~(ROWS'(1) << r);
            if (m_blink && m_frames >= BF) pat = '0;
            else pat = COLS'(glyph_line(m_num, r)) << (COLS - 8);
            e_colr = m_col[0] ? pat : '0;
            e_colg = m_col[1] ? pat : '0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("cycle", {row, colr, colg, frame_start}, {e_row, e_colr, e_colg, e_fs});
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 200);
        if (!frame_start) begin
            checks++;
            errors++;
            $display("FAIL frame_start_timeout got=none exp=pulse t=%0t", $time);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst", {row, colr, colg, frame_start}, {8'hFF, 8'h00, 8'h00, 1'b0});
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] num;
        logic [1:0] color;
        logic [7:0] exp_r;
        logic [7:0] exp_g;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int n, on_cnt, off_cnt;

        vecs[0] = '{4'd2,  2'b11, 8'h66, 8'h66};
        vecs[1] = '{4'd12, 2'b01, 8'h00, 8'h00};
        vecs[2] = '{4'd8,  2'b10, 8'h00, 8'h66};
        vecs[3] = '{4'd0,  2'b01, 8'h42, 8'h00};
        vecs[4] = '{4'd7,  2'b11, 8'h06, 8'h06};
        vecs[5] = '{4'd4,  2'b00, 8'h00, 8'h00};
        vecs[6] = '{4'd9,  2'b01, 8'h66, 8'h00};
        vecs[7] = '{4'd15, 2'b11, 8'h00, 8'h00};

        rst = 1'b1; en = 1'b0; num = 4'd0; color = 2'b00; blink = 1'b0;
        model_reset();
        #2;
        check("reset", {row, colr, colg, frame_start}, {8'hFF, 8'h00, 8'h00, 1'b0});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) tick();
        check("idle_en0", {row, colr, colg, frame_start}, {8'hFF, 8'h00, 8'h00, 1'b0});

        // First enabled edge is a frame end; then blank + drive cycles and frame period.
        num = 4'd2; color = 2'b11; en = 1'b1;
        tick();
        check("first_fs", frame_start, 1'b1);
        check("first_blank", row, 8'hFF);
        tick();
        check("row0_drive", row, 8'hFE);
        wait_fs(n);
        wait_fs(n);
        check("frame_period", n, FRAME);

        // Table: row 2 contents for several digit/colour pairs.
        foreach (vecs[i]) begin
            num = vecs[i].num; color = vecs[i].color;
            wait_fs(n);
            repeat (8) tick();
            check("row2_blank", row, 8'hFF);
            tick();
            check("row2_sel", row, 8'hFB);
            check("row2_colr", colr, vecs[i].exp_r);
            check("row2_colg", colg, vecs[i].exp_g);
        end

        // Mid-frame digit change is deferred to the next frame.
        num = 4'd2; color = 2'b11;
        wait_fs(n);
        repeat (13) tick();
        num = 4'd5;
        repeat (16) tick();
        check("row7_old_glyph", colr, 8'h7E);
        wait_fs(n);
        repeat (5) tick();
        check("row1_new_glyph", {colr, colg}, 16'h7E7E);
        repeat (20) tick();
        check("row6_new_glyph", {colr, colg}, 16'h6666);

        // Blink: over 8 consecutive frames, 4 visible and 4 dark.
        num = 4'd0; color = 2'b10; blink = 1'b1;
        wait_fs(n);
        on_cnt = 0; off_cnt = 0;
        for (int f = 0; f < 8; f++) begin
            repeat (9) tick();
            if (colg == 8'h42) on_cnt++;
            else if (colg == 8'h00) off_cnt++;
            wait_fs(n);
        end
        check("blink_on_frames", on_cnt, 4);
        check("blink_off_frames", off_cnt, 4);
        blink = 1'b0;

        // en drop in row 5, then re-enable with new inputs.
        num = 4'd8; color = 2'b01;
        wait_fs(n);
        repeat (21) tick();
        en = 1'b0;
        tick();
        check("en_drop_idle", {row, colr, colg, frame_start}, {8'hFF, 8'h00, 8'h00, 1'b0});
        num = 4'd3; color = 2'b10; en = 1'b1;
        tick();
        check("reen_fs", {frame_start, row}, {1'b1, 8'hFF});
        tick();
        check("reen_row0", row, 8'hFE);
        repeat (8) tick();
        check("reen_row2", {row, colr, colg}, {8'hFB, 8'h00, 8'h66});

        // Asynchronous reset mid-slot.
        repeat (6) tick();
        pulse_rst();
        tick();
        check("post_rst_fs", frame_start, 1'b1);

        // Randomised run against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) num = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) color = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) blink = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 49) != 0);
            tick();
            if ($urandom_range(0, 499) == 0) pulse_rst();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
